// File: rtl/sum_accumulator.sv
// Accumulates NSAMPLES adder outputs ({carry, sum}) into an ACCBITS-wide total presented via valid/ready.
// Optional SUM_ACCUMULATOR_SATURATE_EN clamps the total to all ones on overflow instead of wrapping.
module sum_accumulator #(
    parameter int unsigned NUMBITS  = 8,
    parameter int unsigned ACCBITS  = 16,
    parameter int unsigned NSAMPLES = 4,
    parameter int unsigned CNTBITS  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [NUMBITS-1:0] in_sum,
    input  logic               in_carry,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACCBITS-1:0] acc_out,
    output logic               overflow,
    output logic               busy,
    output logic [CNTBITS-1:0] sample_count
);

    localparam int unsigned SUMW = ACCBITS + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;

    logic [SUMW-1:0] sample_ext;
    logic [SUMW-1:0] sum_ext;
    logic            last_sample;

    // Sum is one bit wider than the accumulator so its MSB is the overflow indication.
    assign sample_ext  = SUMW'({in_carry, in_sum});
    assign sum_ext     = {1'b0, acc_out} + sample_ext;
    assign last_sample = (sample_count == CNTBITS'(NSAMPLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc_out      <= '0;
            sample_count <= '0;
            overflow     <= 1'b0;
            out_valid    <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_out      <= '0;
                        sample_count <= '0;
                        overflow     <= 1'b0;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
`ifdef SUM_ACCUMULATOR_SATURATE_EN
                        acc_out <= sum_ext[ACCBITS] ? '1 : sum_ext[ACCBITS-1:0];
`else
                        acc_out <= sum_ext[ACCBITS-1:0];
`endif
                        if (sum_ext[ACCBITS]) begin
                            overflow <= 1'b1;
                        end
                        sample_count <= sample_count + CNTBITS'(1);
                        if (last_sample) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
